// File: rtl/register_file_banked_if.sv
// register_file_banked_if -- bus bundle for the banked register file.
//   RS, RT      : read port A / B addresses
//   RD          : write address
//   WriteData   : write data
//   RegWrite    : write enable
//   Save        : request copy main -> shadow
//   Restore     : request copy shadow -> main
//   ReadRS/RT   : combinational read data for ports A / B
//   Busy        : copy in progress
//   Done        : one-cycle pulse at copy completion
// master = requester side, slave = register file side.
interface register_file_banked_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] RS;
   logic [ADDR_W-1:0] RT;
   logic [ADDR_W-1:0] RD;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic              Save;
   logic              Restore;
   logic [DATA_W-1:0] ReadRS;
   logic [DATA_W-1:0] ReadRT;
   logic              Busy;
   logic              Done;

   modport master (
      output RS, RT, RD, WriteData, RegWrite, Save, Restore,
      input  ReadRS, ReadRT, Busy, Done
   );

   modport slave (
      input  RS, RT, RD, WriteData, RegWrite, Save, Restore,
      output ReadRS, ReadRT, Busy, Done
   );
endinterface

// File: rtl/register_file_banked.sv
// register_file_banked -- two-read / one-write register file with a shadow
// bank. Save copies main -> shadow, Restore copies shadow -> main, one
// register per cycle, sequenced by a small FSM.
//   Clock   : rising-edge clock for all state
//   Reset_n : synchronous active-low reset (clears both banks, FSM, index)
//   bus     : register_file_banked_if.slave (addresses, write port,
//             Save/Restore requests, read data, Busy/Done status)
module register_file_banked #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2,
   parameter int ZERO_REG = 0
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   register_file_banked_if.slave  bus
);
   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
   localparam bit                ZERO_EN  = (ZERO_REG != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } state_t;

   logic [DATA_W-1:0] mainBank_r   [DEPTH];
   logic [DATA_W-1:0] shadowBank_r [DEPTH];
   state_t            state_r;
   state_t            nextState_s;
   logic [ADDR_W-1:0] copyIdx_r;
   logic              busy_r;
   logic              done_r;
   logic              wrEn_s;
   logic [DATA_W-1:0] readRs_s;
   logic [DATA_W-1:0] readRt_s;

   // Effective write enable: blocked while copying and for a hardwired R0.
   always_comb begin
      wrEn_s = bus.RegWrite && !busy_r && !(ZERO_EN && (bus.RD == ZERO_IDX));
   end

   // Next-state logic; requests are only looked at in IDLE, Save wins.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.Save) begin
               nextState_s = SAVE;
            end else if (bus.Restore) begin
               nextState_s = RESTORE;
            end else begin
               nextState_s = IDLE;
            end
         end
         SAVE, RESTORE: begin
            if (copyIdx_r == LAST_IDX) begin
               nextState_s = DONE;
            end else begin
               nextState_s = state_r;
            end
         end
         DONE:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // State register plus registered Busy/Done decoded from the next state.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= nextState_s;
         busy_r  <= (nextState_s == SAVE) || (nextState_s == RESTORE);
         done_r  <= (nextState_s == DONE);
      end
   end

   // Copy index: held at 0 outside a copy, steps once per copy cycle and
   // wraps back to 0 after the last register.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         copyIdx_r <= ZERO_IDX;
      end else if ((state_r == SAVE) || (state_r == RESTORE)) begin
         copyIdx_r <= copyIdx_r + ONE_IDX;
      end else begin
         copyIdx_r <= ZERO_IDX;
      end
   end

   // Bank storage: reset clear, one-register copy step, or normal write.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mainBank_r[i]   <= '0;
            shadowBank_r[i] <= '0;
         end
      end else if (state_r == SAVE) begin
         shadowBank_r[copyIdx_r] <= mainBank_r[copyIdx_r];
      end else if (state_r == RESTORE) begin
         if (!(ZERO_EN && (copyIdx_r == ZERO_IDX))) begin
            mainBank_r[copyIdx_r] <= shadowBank_r[copyIdx_r];
         end
      end else if (wrEn_s) begin
         mainBank_r[bus.RD] <= bus.WriteData;
      end
   end

   // Read ports with write-through bypass; a hardwired R0 always reads 0.
   always_comb begin
      if (ZERO_EN && (bus.RS == ZERO_IDX)) begin
         readRs_s = '0;
      end else if (wrEn_s && (bus.RD == bus.RS)) begin
         readRs_s = bus.WriteData;
      end else begin
         readRs_s = mainBank_r[bus.RS];
      end
      if (ZERO_EN && (bus.RT == ZERO_IDX)) begin
         readRt_s = '0;
      end else if (wrEn_s && (bus.RD == bus.RT)) begin
         readRt_s = bus.WriteData;
      end else begin
         readRt_s = mainBank_r[bus.RT];
      end
   end

   assign bus.ReadRS = readRs_s;
   assign bus.ReadRT = readRt_s;
   assign bus.Busy   = busy_r;
   assign bus.Done   = done_r;
endmodule

// File: tb/tb_register_file_banked.sv
// tb_register_file_banked -- directed self-checking bench for
// register_file_banked (DATA_W=16, ADDR_W=2), with a second instance using
// ZERO_REG=1 for the hardwired-R0 behaviour.
module tb_register_file_banked;
   logic Clock = 1'b0;
   logic Reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   register_file_banked_if #(.DATA_W(16), .ADDR_W(2)) bus ();
   register_file_banked_if #(.DATA_W(16), .ADDR_W(2)) zbus ();

   register_file_banked #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .bus(bus)
   );
   register_file_banked #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1)) dutZ (
      .Clock(Clock), .Reset_n(Reset_n), .bus(zbus)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
      bus.RD = a; bus.WriteData = d; bus.RegWrite = 1'b1;
      step();
      bus.RegWrite = 1'b0;
   endtask

   // Steps until Done is seen (bounded), then one more edge back to IDLE.
   task automatic waitDone(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.Done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      step(); step();
      Reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus.RS = 2'(a); bus.RT = 2'(a);
         #1;
         checks++;
         if (bus.ReadRS !== 16'h0000) begin
            errors++; $display("FAIL reset_rs addr=%0d got=%h exp=0000", a, bus.ReadRS);
         end
         checks++;
         if (bus.ReadRT !== 16'h0000) begin
            errors++; $display("FAIL reset_rt addr=%0d got=%h exp=0000", a, bus.ReadRT);
         end
      end
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
         errors++; $display("FAIL reset_status busy=%b done=%b exp=0/0", bus.Busy, bus.Done);
      end
   endtask

   task automatic test_write_read();
      writeReg(2'd2, 16'h0001);
      writeReg(2'd3, 16'h0004);
      bus.RS = 2'd2; bus.RT = 2'd3;
      #1;
      checks++;
      if (bus.ReadRS !== 16'h0001) begin
         errors++; $display("FAIL read_r2 got=%h exp=0001", bus.ReadRS);
      end
      checks++;
      if (bus.ReadRT !== 16'h0004) begin
         errors++; $display("FAIL read_r3 got=%h exp=0004", bus.ReadRT);
      end
      bus.RS = 2'd1; bus.RD = 2'd1; bus.WriteData = 16'h00AA; bus.RegWrite = 1'b1;
      #1;
      checks++;
      if (bus.ReadRS !== 16'h00AA) begin
         errors++; $display("FAIL bypass_rs got=%h exp=00aa", bus.ReadRS);
      end
      step();
      bus.RegWrite = 1'b0; bus.WriteData = 16'h0000;
      #1;
      checks++;
      if (bus.ReadRS !== 16'h00AA) begin
         errors++; $display("FAIL stored_r1 got=%h exp=00aa", bus.ReadRS);
      end
   endtask

   task automatic test_save_restore();
      bit ok;
      writeReg(2'd1, 16'h0011);
      writeReg(2'd2, 16'h0022);
      writeReg(2'd3, 16'h0033);
      bus.Save = 1'b1;
      step();
      bus.Save = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            errors++; $display("FAIL save_busy cycle=%0d busy=%b done=%b exp=1/0", i, bus.Busy, bus.Done);
         end
         step();
      end
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
         errors++; $display("FAIL save_done busy=%b done=%b exp=0/1", bus.Busy, bus.Done);
      end
      step();
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
         errors++; $display("FAIL save_idle busy=%b done=%b exp=0/0", bus.Busy, bus.Done);
      end
      writeReg(2'd1, 16'hFFFF);
      bus.RS = 2'd1;
      #1;
      checks++;
      if (bus.ReadRS !== 16'hFFFF) begin
         errors++; $display("FAIL overwrite_r1 got=%h exp=ffff", bus.ReadRS);
      end
      bus.Restore = 1'b1;
      step();
      bus.Restore = 1'b0;
      waitDone(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL restore_timeout done never seen got=0 exp=1");
      end
      bus.RS = 2'd1; bus.RT = 2'd2;
      #1;
      checks++;
      if (bus.ReadRS !== 16'h0011 || bus.ReadRT !== 16'h0022) begin
         errors++; $display("FAIL restore_r1r2 got=%h/%h exp=0011/0022", bus.ReadRS, bus.ReadRT);
      end
      bus.RT = 2'd3;
      #1;
      checks++;
      if (bus.ReadRT !== 16'h0033) begin
         errors++; $display("FAIL restore_r3 got=%h exp=0033", bus.ReadRT);
      end
   endtask

   task automatic test_busy_and_priority();
      bit ok;
      bus.Save = 1'b1;
      step();
      bus.Save = 1'b0;
      bus.RegWrite = 1'b1; bus.RD = 2'd2; bus.WriteData = 16'hBEEF; bus.RS = 2'd2;
      bus.Restore = 1'b1;
      #1;
      checks++;
      if (bus.ReadRS !== 16'h0022) begin
         errors++; $display("FAIL busy_no_bypass got=%h exp=0022", bus.ReadRS);
      end
      step();
      bus.RegWrite = 1'b0; bus.Restore = 1'b0;
      waitDone(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL busy_save_timeout done never seen got=0 exp=1");
      end
      step();
      checks++;
      if (bus.Busy !== 1'b0) begin
         errors++; $display("FAIL request_not_queued busy=%b exp=0", bus.Busy);
      end
      checks++;
      if (bus.ReadRS !== 16'h0022) begin
         errors++; $display("FAIL busy_write_dropped got=%h exp=0022", bus.ReadRS);
      end
      writeReg(2'd1, 16'h0055);
      bus.Save = 1'b1; bus.Restore = 1'b1;
      step();
      bus.Save = 1'b0; bus.Restore = 1'b0;
      waitDone(ok);
      bus.RS = 2'd1;
      #1;
      checks++;
      if (!ok || bus.ReadRS !== 16'h0055) begin
         errors++; $display("FAIL both_req_main ok=%b r1=%h exp=1/0055", ok, bus.ReadRS);
      end
      writeReg(2'd1, 16'h0066);
      bus.Restore = 1'b1;
      step();
      bus.Restore = 1'b0;
      waitDone(ok);
      bus.RS = 2'd1;
      #1;
      checks++;
      if (!ok || bus.ReadRS !== 16'h0055) begin
         errors++; $display("FAIL both_req_saved ok=%b r1=%h exp=1/0055", ok, bus.ReadRS);
      end
   endtask

   task automatic test_zero_reg();
      zbus.RS = 2'd0; zbus.RD = 2'd0; zbus.WriteData = 16'h1234; zbus.RegWrite = 1'b1;
      #1;
      checks++;
      if (zbus.ReadRS !== 16'h0000) begin
         errors++; $display("FAIL zero_r0_before got=%h exp=0000", zbus.ReadRS);
      end
      step();
      zbus.RegWrite = 1'b0;
      #1;
      checks++;
      if (zbus.ReadRS !== 16'h0000) begin
         errors++; $display("FAIL zero_r0_after got=%h exp=0000", zbus.ReadRS);
      end
      zbus.RD = 2'd1; zbus.WriteData = 16'h5A5A; zbus.RegWrite = 1'b1; zbus.RT = 2'd1;
      step();
      zbus.RegWrite = 1'b0;
      #1;
      checks++;
      if (zbus.ReadRT !== 16'h5A5A) begin
         errors++; $display("FAIL zero_r1_write got=%h exp=5a5a", zbus.ReadRT);
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      bit sawDone;
      bus.Save = 1'b1;
      step();
      bus.Save = 1'b0;
      step();
      Reset_n = 1'b0;
      step();
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
         errors++; $display("FAIL abort_status busy=%b done=%b exp=0/0", bus.Busy, bus.Done);
      end
      Reset_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) sawDone = 1'b1;
      end
      checks++;
      if (sawDone) begin
         errors++; $display("FAIL abort_no_done activity=1 exp=0");
      end
      for (int a = 0; a < 4; a++) begin
         bus.RS = 2'(a);
         #1;
         checks++;
         if (bus.ReadRS !== 16'h0000) begin
            errors++; $display("FAIL abort_main addr=%0d got=%h exp=0000", a, bus.ReadRS);
         end
      end
      bus.Restore = 1'b1;
      step();
      bus.Restore = 1'b0;
      waitDone(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL abort_restore_timeout done never seen got=0 exp=1");
      end
      for (int a = 0; a < 4; a++) begin
         bus.RS = 2'(a);
         #1;
         checks++;
         if (bus.ReadRS !== 16'h0000) begin
            errors++; $display("FAIL abort_shadow addr=%0d got=%h exp=0000", a, bus.ReadRS);
         end
      end
   endtask

   initial begin
      bus.RS = 2'd0; bus.RT = 2'd0; bus.RD = 2'd0; bus.WriteData = 16'h0000;
      bus.RegWrite = 1'b0; bus.Save = 1'b0; bus.Restore = 1'b0;
      zbus.RS = 2'd0; zbus.RT = 2'd0; zbus.RD = 2'd0; zbus.WriteData = 16'h0000;
      zbus.RegWrite = 1'b0; zbus.Save = 1'b0; zbus.Restore = 1'b0;
      test_reset();
      test_write_read();
      test_save_restore();
      test_busy_and_priority();
      test_zero_reg();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/register_file_banked.md
REGISTER_FILE_BANKED -- requirements
Module: register_file_banked

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits; SHALL be 8 or greater.
REQ-002 Parameter ADDR_W, default 2: register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 SHALL be hardwired to zero.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Clock  input  1  rising-edge clock for all state.
REQ-006 Reset_n  input  1  synchronous active-low reset.
REQ-007 RS  input  ADDR_W  read port A address.
REQ-008 RT  input  ADDR_W  read port B address.
REQ-009 RD  input  ADDR_W  write address.
REQ-010 WriteData  input  DATA_W  write data.
REQ-011 RegWrite  input  1  write enable.
REQ-012 Save  input  1  request to copy the main bank to the shadow bank.
REQ-013 Restore  input  1  request to copy the shadow bank to the main bank.
REQ-014 ReadRS  output  DATA_W  port A read data.
REQ-015 ReadRT  output  DATA_W  port B read data.
REQ-016 Busy  output  1  high while a save or restore copy is in progress.
REQ-017 Done  output  1  one-cycle pulse when a copy completes.

Function
REQ-018 Storage SHALL be two banks, main and shadow, each DEPTH x DATA_W.
REQ-019 ReadRS/ReadRT SHALL be combinational reads of main[RS]/main[RT].
REQ-020 Write-through bypass: if RegWrite=1, Busy=0 and RD==RS, ReadRS SHALL equal WriteData in the same cycle; the same rule applies to RD==RT for ReadRT.
REQ-021 Writes: main[RD] <= WriteData at the rising edge when RegWrite=1 and Busy=0.
REQ-022 RegWrite while Busy=1 SHALL be ignored, with no write and no bypass.
REQ-023 ZERO_REG=1: reads of address 0 SHALL return 0; writes to address 0 SHALL be dropped; no bypass applies for address 0.
REQ-024 FSM states SHALL be IDLE, SAVE, RESTORE and DONE; Busy=1 only in SAVE or RESTORE; Done=1 only in DONE.
REQ-025 In IDLE, Save=1 SHALL go to SAVE and Restore=1 SHALL go to RESTORE; if both are high, Save SHALL win.
REQ-026 Save and Restore SHALL be sampled only in IDLE; requests in SAVE, RESTORE or DONE SHALL be ignored and not queued.
REQ-027 An index counter of ADDR_W bits SHALL start at 0 on entry to SAVE/RESTORE; each cycle in those states copies one register at the rising edge, then the index increments.
REQ-028 In SAVE, the copy SHALL be shadow[idx] <= main[idx]; in RESTORE, main[idx] <= shadow[idx]; with ZERO_REG=1, main[0] SHALL stay 0.
REQ-029 After the copy at idx = DEPTH-1, the FSM SHALL go to DONE; the index SHALL wrap to 0; Busy SHALL be high for exactly DEPTH cycles.
REQ-030 DONE SHALL last one cycle and then return to IDLE.
REQ-031 Latency: with a request sampled at edge n, Busy is high from edge n to edge n+DEPTH, Done is high from edge n+DEPTH to edge n+DEPTH+1, and the next request is accepted at edge n+DEPTH+2 or later.
REQ-032 During RESTORE, reads SHALL return the current, partially restored main contents; the consumer SHALL wait for Done.

Reset
REQ-033 Reset_n=0 at a rising edge SHALL clear both banks to 0, set the FSM to IDLE and the index to 0, and force Busy=0 and Done=0.
REQ-034 Reset SHALL take priority over writes and over Save/Restore.
REQ-035 Reset during SAVE/RESTORE SHALL abort the copy, with no Done pulse; Busy SHALL be 0 after that edge.

Verification (DATA_W=16, ADDR_W=2)
REQ-036 Reset, then RS/RT swept over 0..3 -> ReadRS=ReadRT=0x0000 for every address, Busy=0, Done=0.
REQ-037 Write R2=0x0001 then R3=0x0004, then RS=2, RT=3 -> ReadRS=0x0001, ReadRT=0x0004; RegWrite=1, RD=1, WriteData=0x00AA with RS=1 before the edge -> ReadRS=0x00AA in the same cycle.
REQ-038 R1..R3=0x0011/0x0022/0x0033, pulse Save -> Busy high 4 cycles, Done pulse 1 cycle; then write R1=0xFFFF and pulse Restore -> after Done, R1=0x0011, R2=0x0022, R3=0x0033.
REQ-039 RegWrite RD=2, WriteData=0xBEEF during SAVE -> R2 unchanged and no bypass; Save and Restore asserted in the same IDLE cycle -> SAVE runs and Restore is dropped.
REQ-040 ZERO_REG=1: write R0=0x1234 with RS=0 -> ReadRS=0x0000 before and after the edge.
REQ-041 Reset_n=0 in the 2nd SAVE cycle -> next cycle Busy=0, no Done pulse, and all shadow and main registers read 0.
